// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C slave controller: FSM states, ACK/NACK levels
// and the SDA hold-time computation.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Clocks to wait after SCL falls before SDA may change; never less than one.
  function automatic int unsigned hold_cycles(input int unsigned clock_rate,
                                              input int unsigned freq);
    int unsigned h;
    h = clock_rate / (freq * 20);
    return (h == 0) ? 1 : h;
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop synchronisers, optional 3-sample majority filter
// (I2C_SLAVE_GLITCH_FILTER_EN) and SCL edge / START / STOP detection.
module i2c_line_cond (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic       scl_lvl, sda_lvl;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_comb begin
    scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_lvl = maj3(scl_hist_q);
  assign sda_lvl = maj3(sda_hist_q);
`else
  assign scl_lvl = scl_sync_q[1];
  assign sda_lvl = sda_sync_q[1];
`endif

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_prev_d = scl_lvl;
    sda_prev_d = sda_lvl;
  end

  // Idle bus is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_lvl_o  = sda_lvl;
  assign scl_rise_o = scl_lvl & ~scl_prev_q;
  assign scl_fall_o = ~scl_lvl & scl_prev_q;
  assign start_o    = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
  assign stop_o     = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C 7-bit slave bridging SCL/SDA to a byte strobe interface with a one-byte TX buffer.
// Optional input glitch filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned FREQ       = 100_000,
  parameter int unsigned CLOCK_RATE = 40_000_000,
  parameter logic [6:0]  ADDRESS    = 7'b0001111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  input  logic [7:0] as_data_i,
  input  logic       as_dstrb_i,
  output logic       as_busy_o,
  output logic [7:0] as_data_o,
  output logic       as_dstrb_o
);

  localparam int unsigned Hold  = hold_cycles(CLOCK_RATE, FREQ);
  localparam int unsigned HoldW = $clog2(Hold + 1);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_cond u_line_cond (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_lvl_o  (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d, shift_in;
  logic             oen_q, oen_d, oen_tgt;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]       tx_buf_q, tx_buf_d;
  logic             tx_full_q, tx_full_d, unload;
  logic [7:0]       data_q, data_d;
  logic             dstrb_q, dstrb_d;

  assign shift_in = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    oen_d      = oen_q;
    hold_cnt_d = hold_cnt_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    data_d     = data_q;
    dstrb_d    = 1'b0;
    unload     = 1'b0;
    oen_tgt    = I2C_NACK;

    case (state_q)
      StAddr, StWrData: begin
        if (scl_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == StAddr) begin
              state_d = (shift_in[7:1] == ADDRESS) ? StAddrAck : StIgnore;
            end else begin
              data_d  = shift_in;
              dstrb_d = 1'b1;
              state_d = StWrAck;
            end
          end
        end
      end
      StAddrAck: begin
        oen_tgt = I2C_ACK;
        if (scl_rise) begin
          bit_cnt_d = 3'd0;
          if (shift_q[0]) begin
            state_d = StRdData;
            unload  = 1'b1;
            shift_d = tx_full_q ? tx_buf_q : 8'hFF;
          end else begin
            state_d = StWrData;
          end
        end
      end
      StWrAck: begin
        oen_tgt = I2C_ACK;
        if (scl_rise) begin
          bit_cnt_d = 3'd0;
          state_d   = StWrData;
        end
      end
      StRdData: begin
        oen_tgt = shift_q[7];
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], 1'b1};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StRdAck;
        end
      end
      StRdAck: begin
        if (scl_rise) begin
          if (sda_lvl == I2C_ACK) begin
            state_d   = StRdData;
            bit_cnt_d = 3'd0;
            unload    = 1'b1;
            shift_d   = tx_full_q ? tx_buf_q : 8'hFF;
          end else begin
            state_d = StIgnore;
          end
        end
      end
      default: ;
    endcase

    // SDA only moves a hold time after SCL falls, so the master sees stable data.
    if (scl_fall) begin
      hold_cnt_d = HoldW'(Hold);
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HoldW'(1);
      if (hold_cnt_q == HoldW'(1)) oen_d = oen_tgt;
    end

    if (unload) tx_full_d = 1'b0;
    if (as_dstrb_i && !tx_full_d) begin
      tx_buf_d  = as_data_i;
      tx_full_d = 1'b1;
    end

    if (stop_det) begin
      state_d    = StIdle;
      oen_d      = 1'b1;
      hold_cnt_d = '0;
    end else if (start_det) begin
      state_d    = StAddr;
      bit_cnt_d  = 3'd0;
      oen_d      = 1'b1;
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      oen_q      <= 1'b1;
      hold_cnt_q <= '0;
      tx_buf_q   <= 8'h00;
      tx_full_q  <= 1'b0;
      data_q     <= 8'h00;
      dstrb_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      oen_q      <= oen_d;
      hold_cnt_q <= hold_cnt_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      data_q     <= data_d;
      dstrb_q    <= dstrb_d;
    end
  end

  assign scl_o      = 1'b1;
  assign sda_o      = 1'b0;
  assign sda_oen    = oen_q;
  assign as_busy_o  = tx_full_q;
  assign as_data_o  = data_q;
  assign as_dstrb_o = dstrb_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bit-banged I2C master, transaction-level slave model and a
// per-cycle compare process, with directed scenarios followed by randomized transfers.
module tb_i2c_slave_ctrl;

  localparam int unsigned Freq      = 100_000;
  localparam int unsigned ClockRate = 4_000_000;
  localparam logic [6:0]  Addr      = 7'h0F;
  localparam int          Quarter   = 10;
  localparam int          Half      = 20;

  localparam int PIdle = 0, PAddr = 1, PWr = 2, PRd = 3, PIgn = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       scl_o, sda_o, sda_oen;
  logic [7:0] as_data_i, as_data_o;
  logic       as_dstrb_i, as_busy_o, as_dstrb_o;
  logic       scl_bus, sda_bus;

  always #5 clk = ~clk;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & (sda_oen | sda_o);

  i2c_slave_ctrl #(
    .FREQ       (Freq),
    .CLOCK_RATE (ClockRate),
    .ADDRESS    (Addr)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_bus),
    .scl_o      (scl_o),
    .sda_i      (sda_bus),
    .sda_o      (sda_o),
    .sda_oen    (sda_oen),
    .as_data_i  (as_data_i),
    .as_dstrb_i (as_dstrb_i),
    .as_busy_o  (as_busy_o),
    .as_data_o  (as_data_o),
    .as_dstrb_o (as_dstrb_o)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the slave
  int         phase;
  logic [7:0] m_buf, m_cur;
  logic       m_full;
  logic [7:0] wr_q[$];

  logic bit_hi, exp_oen, busy_chk;
  bit   dstrb_prev = 1'b0;

  always @(negedge clk) begin
    if (bit_hi) begin
      checks++;
      if (sda_oen !== exp_oen) begin
        errors++;
        $display("FAIL sda_oen: got %b expected %b at %0t", sda_oen, exp_oen, $time);
      end
    end
    if (busy_chk && !bit_hi) begin
      checks++;
      if (as_busy_o !== m_full) begin
        errors++;
        $display("FAIL as_busy_o: got %b expected %b at %0t", as_busy_o, m_full, $time);
      end
    end
    if (as_dstrb_o === 1'b1) begin
      logic [7:0] e;
      checks++;
      if (dstrb_prev) begin
        errors++;
        $display("FAIL dstrb width: got 2+ clk pulse expected 1 clk at %0t", $time);
      end else if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL dstrb: got unexpected pulse data %h expected none at %0t",
                 as_data_o, $time);
      end else begin
        e = wr_q.pop_front();
        if (as_data_o !== e) begin
          errors++;
          $display("FAIL as_data_o: got %h expected %h at %0t", as_data_o, e, $time);
        end
      end
    end
    dstrb_prev = (as_dstrb_o === 1'b1);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_load();
    m_cur  = m_full ? m_buf : 8'hFF;
    m_full = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d);
    as_data_i  = d;
    as_dstrb_i = 1'b1;
    tick(1);
    as_dstrb_i = 1'b0;
    if (!m_full) begin
      m_buf  = d;
      m_full = 1'b1;
    end
  endtask

  // One bit; leaves SCL high so the caller can update the model before scl_low().
  task automatic clk_bit(input logic drv, input logic exp, input bit glitch, output logic got);
    tick(Quarter);
    sda_m = drv;
    tick(Quarter);
    exp_oen = exp;
    scl_m   = 1'b1;
    bit_hi  = 1'b1;
    tick(Half / 2);
    if (glitch) begin
      sda_m = 1'b0;
      tick(1);
      sda_m = drv;
      tick(Half / 2 - 1);
    end else begin
      tick(Half / 2);
    end
    got = sda_bus;
  endtask

  task automatic scl_low();
    bit_hi = 1'b0;
    scl_m  = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      tick(Quarter);
      sda_m = 1'b1;
      tick(Quarter);
      scl_m = 1'b1;
      tick(Half);
    end
    sda_m = 1'b0;
    tick(Half);
    scl_m = 1'b0;
    phase = PAddr;
  endtask

  task automatic i2c_stop();
    tick(Quarter);
    sda_m = 1'b0;
    tick(Quarter);
    scl_m = 1'b1;
    tick(Half);
    sda_m = 1'b1;
    tick(2 * Half);
    phase = PIdle;
  endtask

  task automatic send_bits(input logic [7:0] b, input int glitch_at);
    logic got;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && phase == PWr) wr_q.push_back(b);
      clk_bit(b[i], 1'b1, (i == glitch_at), got);
      scl_low();
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, input int glitch_at);
    logic got, ack_exp;
    send_bits(b, glitch_at);
    if (phase == PAddr) ack_exp = (b[7:1] == Addr) ? 1'b0 : 1'b1;
    else if (phase == PWr) ack_exp = 1'b0;
    else ack_exp = 1'b1;
    clk_bit(1'b1, ack_exp, 1'b0, got);
    if (phase == PAddr) begin
      if (b[7:1] != Addr) phase = PIgn;
      else if (b[0]) begin
        phase = PRd;
        m_load();
      end else phase = PWr;
    end
    scl_low();
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] data);
    logic got;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, m_cur[i], 1'b0, got);
      data[i] = got;
      scl_low();
    end
    clk_bit(mack, 1'b1, 1'b0, got);
    if (mack == 1'b0) m_load();
    else phase = PIgn;
    scl_low();
  endtask

  initial begin
    logic [7:0] d;
    logic [6:0] ra;
    logic       rrw;
    int         n;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    as_data_i = 8'h00; as_dstrb_i = 1'b0;
    bit_hi = 1'b0; exp_oen = 1'b1; busy_chk = 1'b0;
    phase = PIdle; m_full = 1'b0; m_buf = 8'h00; m_cur = 8'hFF;
    tick(3);
    chk("reset sda_oen", {7'd0, sda_oen}, 8'h01);
    chk("reset busy", {7'd0, as_busy_o}, 8'h00);
    chk("reset dstrb", {7'd0, as_dstrb_o}, 8'h00);
    chk("reset data", as_data_o, 8'h00);
    chk("scl_o tie", {7'd0, scl_o}, 8'h01);
    chk("sda_o tie", {7'd0, sda_o}, 8'h00);
    reset = 1'b0;
    tick(5);
    busy_chk = 1'b1;

    // Plain write
    i2c_start(); wr_byte(8'h1E, -1); wr_byte(8'h45, -1); i2c_stop();
    chk("write data", as_data_o, 8'h45);

    // Read one byte from a loaded buffer, master NACK
    strobe(8'h44);
    chk("busy after strobe", {7'd0, as_busy_o}, 8'h01);
    i2c_start(); wr_byte(8'h1F, -1); rd_byte(1'b1, d); i2c_stop();
    chk("read byte", d, 8'h44);
    chk("busy after load", {7'd0, as_busy_o}, 8'h00);

    // Foreign address: ignored, including following data
    i2c_start(); wr_byte(8'h20, -1); wr_byte(8'h77, -1); i2c_stop();
    chk("data after foreign addr", as_data_o, 8'h45);

    // Empty buffer reads 0xFF; buffer filled mid-read feeds the second byte
    i2c_start(); wr_byte(8'h1F, -1); strobe(8'hC3);
    rd_byte(1'b0, d); chk("empty read", d, 8'hFF);
    rd_byte(1'b1, d); chk("second read", d, 8'hC3);
    i2c_stop();

    // Repeated START from write into read
    strobe(8'h3C);
    i2c_start(); wr_byte(8'h1E, -1); wr_byte(8'h99, -1);
    i2c_start(); wr_byte(8'h1F, -1); rd_byte(1'b1, d); i2c_stop();
    chk("repeated start read", d, 8'h3C);

    // Reset while the slave drives the write ACK
    strobe(8'h5A);
    i2c_start(); wr_byte(8'h1E, -1); send_bits(8'hAB, -1);
    tick(Quarter);
    chk("ack before reset", {7'd0, sda_oen}, 8'h00);
    reset = 1'b1; busy_chk = 1'b0; m_full = 1'b0; phase = PIdle;
    #1;
    chk("mid reset sda_oen", {7'd0, sda_oen}, 8'h01);
    chk("mid reset busy", {7'd0, as_busy_o}, 8'h00);
    chk("mid reset data", as_data_o, 8'h00);
    tick(2);
    reset = 1'b0;
    sda_m = 1'b1;
    i2c_stop();
    busy_chk = 1'b1;
    i2c_start(); wr_byte(8'h1E, -1); wr_byte(8'h12, -1); i2c_stop();
    chk("write after reset", as_data_o, 8'h12);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    i2c_start(); wr_byte(8'h1E, -1); wr_byte(8'hFF, 4); wr_byte(8'h81, -1); i2c_stop();
    chk("write with glitch", as_data_o, 8'h81);
`endif

    for (int t = 0; t < 20; t++) begin
      ra  = ($urandom_range(0, 3) != 0) ? Addr : 7'($urandom);
      rrw = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) strobe(8'($urandom));
      i2c_start();
      wr_byte({ra, rrw}, -1);
      if (phase == PRd) begin
        for (int k = 0; k < n; k++) begin
          if ($urandom_range(0, 1) == 1) strobe(8'($urandom));
          rd_byte((k == n - 1), d);
        end
      end else begin
        for (int k = 0; k < n; k++) wr_byte(8'($urandom), -1);
      end
      if ($urandom_range(0, 2) != 0) i2c_stop();
    end
    if (!scl_m) i2c_stop();
    tick(10);

    chk("pending strobes", 8'(wr_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
